// File: rtl/sync_fifo2_pkg.sv
// sync_fifo2_pkg: shared definitions for the sync_fifo2 single-clock FIFO.
//   - default data/address widths
//   - count_t: occupancy type for the default geometry (ASIZE+1 bits)
//   - next_count(): occupancy update from the accept/flush bits of one cycle
// Optional build macro used by the family: SYNC_FIFO2_ERR_EN (see sync_fifo2.sv).

package sync_fifo2_pkg;

   localparam int unsigned DefDsize = 8;
   localparam int unsigned DefAsize = 4;

   // One extra bit so that "full" (== 2**ASIZE) is representable.
   typedef logic [DefAsize:0] count_t;

   // Next occupancy. flush dominates; a simultaneous accepted write and read
   // leave the count unchanged. Computed at 32 bits so it serves any ASIZE;
   // the caller truncates to its own count width.
   function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                              input logic        wr_acc,
                                              input logic        rd_acc,
                                              input logic        flush);
      logic [31:0] nxt;
      nxt = cnt;
      if (flush) begin
         nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         nxt = cnt + 32'd1;
      end else if (rd_acc && !wr_acc) begin
         nxt = cnt - 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sync_fifo2_mem.sv
// sync_fifo2_mem: storage array for sync_fifo2.
//   2**ASIZE words of DSIZE bits, one clocked write port with enable and one
//   asynchronous (combinational) read port. The array has no reset; validity
//   of its contents is tracked by the pointers/count in the parent.
// Ports:
//   clk_i    clock, write on rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, mem[raddr_i]

module sync_fifo2_mem
   import sync_fifo2_pkg::*;
#(
   parameter int unsigned DSIZE = DefDsize,
   parameter int unsigned ASIZE = DefAsize
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [ASIZE-1:0] raddr_i,
   output logic [DSIZE-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** ASIZE;

   logic [DSIZE-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo2.sv
// sync_fifo2: single-clock parametrised FIFO with show-ahead read data.
//   Occupancy count, programmable almost-full/almost-empty thresholds,
//   synchronous flush. Sticky overflow/underflow flags are built only when
//   the macro SYNC_FIFO2_ERR_EN is defined; otherwise they are tied low and
//   err_clr is ignored (ports exist in both builds).
// Parameters:
//   DSIZE          data width
//   ASIZE          address width, depth = 2**ASIZE
//   AFULL_THRESH   walmost_full when count >= AFULL_THRESH
//   AEMPTY_THRESH  ralmost_empty when count <= AEMPTY_THRESH
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   winc / wdata   write request / data (accepted when !wfull)
//   rinc           read request, pops head (accepted when !rempty)
//   flush          synchronous clear of pointers and count, highest priority
//   err_clr        synchronous clear of sticky error flags
//   rdata          head-of-queue data, 0 while empty
//   wfull, rempty, walmost_full, ralmost_empty, count   status from registered count
//   overflow, underflow                                  sticky error flags

module sync_fifo2
   import sync_fifo2_pkg::*;
#(
   parameter int unsigned DSIZE         = DefDsize,
   parameter int unsigned ASIZE         = DefAsize,
   parameter int unsigned AFULL_THRESH  = 2 ** ASIZE - 4,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   input  logic             flush,
   input  logic             err_clr,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned CntW = ASIZE + 1;
   localparam int unsigned PtrW = ASIZE;

   localparam logic [ASIZE:0]   DepthCnt = CntW'(2 ** ASIZE);
   localparam logic [ASIZE:0]   AfullTh  = CntW'(AFULL_THRESH);
   localparam logic [ASIZE:0]   AemptyTh = CntW'(AEMPTY_THRESH);
   localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);

   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [ASIZE:0]   count_q, count_d;
   logic             wr_acc, rd_acc;
   logic [DSIZE-1:0] mem_rdata;

   // ---------------------------------------------------------------------------
   // Status flags, decoded from the registered count only
   // ---------------------------------------------------------------------------
   assign wfull         = (count_q == DepthCnt);
   assign rempty        = (count_q == '0);
   assign walmost_full  = (count_q >= AfullTh);
   assign ralmost_empty = (count_q <= AemptyTh);
   assign count         = count_q;

   // ---------------------------------------------------------------------------
   // Accept decisions. At full a concurrent read does not make room for the
   // write in the same cycle (and vice versa at empty), since both use the
   // registered flags.
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_acc = winc && !wfull && !flush;
      rd_acc = rinc && !rempty && !flush;
   end

   // ---------------------------------------------------------------------------
   // Pointer and count next state
   // ---------------------------------------------------------------------------
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + PtrOne;
         end
         if (rd_acc) begin
            rptr_d = rptr_q + PtrOne;
         end
      end
      count_d = CntW'(next_count(32'(count_q), wr_acc, rd_acc, flush));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   sync_fifo2_mem #(
      .DSIZE(DSIZE),
      .ASIZE(ASIZE)
   ) u_mem (
      .clk_i  (clk),
      .we_i   (wr_acc),
      .waddr_i(wptr_q),
      .wdata_i(wdata),
      .raddr_i(rptr_q),
      .rdata_o(mem_rdata)
   );

   // Stale array contents are never exposed while empty.
   assign rdata = rempty ? '0 : mem_rdata;

   // ---------------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO2_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Set has priority over err_clr; flush neither sets nor clears.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (winc && wfull && !flush) begin
         overflow_d = 1'b1;
      end
      if (rinc && rempty && !flush) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;

   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo2.sv
// tb_sync_fifo2: self-checking bench for sync_fifo2 (DSIZE=8, ASIZE=4,
// AFULL_THRESH=12, AEMPTY_THRESH=2). A queue-based reference model tracks the
// FIFO contents; expected read data is queued when a read is issued and a
// separate monitor compares it on every accepted read at the DUT.

module tb_sync_fifo2;

   localparam int unsigned Depth = 16;

   logic       clk;
   logic       rst;
   logic       winc;
   logic [7:0] wdata;
   logic       rinc;
   logic       flush;
   logic       err_clr;
   logic [7:0] rdata;
   logic       wfull;
   logic       rempty;
   logic       walmost_full;
   logic       ralmost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   sync_fifo2 #(
      .DSIZE        (8),
      .ASIZE        (4),
      .AFULL_THRESH (12),
      .AEMPTY_THRESH(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .winc         (winc),
      .wdata        (wdata),
      .rinc         (rinc),
      .flush        (flush),
      .err_clr      (err_clr),
      .rdata        (rdata),
      .wfull        (wfull),
      .rempty       (rempty),
      .walmost_full (walmost_full),
      .ralmost_empty(ralmost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all status outputs against the model's view of the FIFO.
   task automatic check_state(input string tag);
      int sz;
      sz = model_q.size();
      chk({tag, ".count"}, 32'(count), 32'(sz));
      chk({tag, ".wfull"}, 32'(wfull), 32'(sz == Depth));
      chk({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
      chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(sz >= 12));
      chk({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(sz <= 2));
      chk({tag, ".rdata"}, 32'(rdata), (sz == 0) ? 32'd0 : 32'(model_q[0]));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
   endtask

   // Issue one cycle of stimulus (called just after a falling edge), update the
   // model, then let one rising edge pass and check on the following falling edge.
   task automatic drive(input bit w, input logic [7:0] wd, input bit r, input bit f,
                        input bit ec, input string tag);
      bit full_m;
      bit empty_m;
      full_m  = (model_q.size() == Depth);
      empty_m = (model_q.size() == 0);
      winc    = w;
      wdata   = wd;
      rinc    = r;
      flush   = f;
      err_clr = ec;
      if (f) begin
         model_q.delete();
      end else begin
         if (r && !empty_m) begin
            exp_q.push_back(model_q[0]);
            void'(model_q.pop_front());
         end
         if (w && !full_m) begin
            model_q.push_back(wd);
         end
      end
`ifdef SYNC_FIFO2_ERR_EN
      if (ec) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (w && full_m && !f) m_ovf = 1'b1;
      if (r && empty_m && !f) m_udf = 1'b1;
`endif
      @(posedge clk);
      @(negedge clk);
      winc    = 1'b0;
      rinc    = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      check_state(tag);
   endtask

   // Monitor: every read the DUT accepts must match the next expected word.
   always @(posedge clk) begin
      if (!rst && rinc && !rempty && !flush) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL read_unexpected: got 0x%0h expected no read at %0t", rdata, $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rdata !== e) begin
               n_errors++;
               $display("FAIL read_data: got 0x%0h expected 0x%0h at %0t", rdata, e, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      winc    = 1'b0;
      wdata   = 8'h00;
      rinc    = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      check_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Fill 0x00..0x0F, then a dropped 17th write, then drain in order.
      for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0, 0, "fill");
      drive(1, 8'hEE, 0, 0, 0, "fill_drop");
      for (int i = 0; i < 16; i++) drive(0, 8'h00, 1, 0, 0, "drain");

      // Wrap / steady state: preload 5, then concurrent read+write for 40 cycles.
      for (int i = 0; i < 5; i++) drive(1, 8'(8'h40 + i), 0, 0, 0, "preload");
      for (int i = 0; i < 40; i++) drive(1, 8'(8'h80 + i), 1, 0, 0, "steady");
      for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0, 0, "steady_drain");

      // Full with winc && rinc: read wins, written word is lost.
      for (int i = 0; i < 16; i++) drive(1, 8'(8'h10 + i), 0, 0, 0, "refill");
      drive(1, 8'hBB, 1, 0, 0, "full_both");
      for (int i = 0; i < 15; i++) drive(0, 8'h00, 1, 0, 0, "full_drain");

      // Empty with winc && rinc: write wins, data shows ahead right away.
      drive(1, 8'h5C, 1, 0, 0, "empty_both");
      drive(0, 8'h00, 1, 0, 0, "empty_drain");

      // Flush at count 9 with a concurrent write.
      for (int i = 0; i < 9; i++) drive(1, 8'(8'h20 + i), 0, 0, 0, "pre_flush");
      drive(1, 8'h77, 0, 1, 0, "flush");
      drive(1, 8'hA5, 0, 0, 0, "post_flush_wr");
      drive(0, 8'h00, 1, 0, 0, "post_flush_rd");

      // Asynchronous reset mid-operation at count 7.
      for (int i = 0; i < 7; i++) drive(1, 8'(8'h30 + i), 0, 0, 0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_state("async_rst");
      @(negedge clk);
      check_state("rst_hold");
      rst = 1'b0;
      drive(1, 8'h3C, 0, 0, 0, "post_rst_wr");
      drive(0, 8'h00, 1, 0, 0, "post_rst_rd");

      // Error flags: underflow at empty, overflow at full, survive flush, clear.
      drive(0, 8'h00, 1, 0, 0, "underflow");
      for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0, 0, "err_fill");
      drive(1, 8'hFF, 0, 0, 0, "overflow");
      drive(0, 8'h00, 0, 1, 0, "err_flush");
      drive(0, 8'h00, 0, 0, 1, "err_clr");
      drive(0, 8'h00, 0, 0, 0, "err_idle");

      // Randomised traffic, two phases biased towards filling then draining.
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            bit w, r, f, ec;
            w  = ($urandom_range(99) < ((ph == 0) ? 65 : 40));
            r  = ($urandom_range(99) < ((ph == 0) ? 40 : 65));
            f  = ($urandom_range(99) < 2);
            ec = ($urandom_range(99) < 4);
            drive(w, 8'($urandom), r, f, ec, "random");
         end
      end
      while (model_q.size() != 0) drive(0, 8'h00, 1, 0, 0, "final_drain");

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
